// File: rtl/fdtd_stream_align.sv
// Re-pairs two skewed operand streams: one show-ahead FIFO per lane, a pair is
// emitted only while both lanes hold data, and both lanes always pop together.
module fdtd_stream_align #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       clear_i,
  input  logic                       a_valid_i,
  input  logic [DATA_WIDTH-1:0]      a_data_i,
  output logic                       a_ready_o,
  input  logic                       b_valid_i,
  input  logic [DATA_WIDTH-1:0]      b_data_i,
  output logic                       b_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_a_o,
  output logic [DATA_WIDTH-1:0]      out_b_o,
  output logic [$clog2(DEPTH):0]     a_level_o,
  output logic [$clog2(DEPTH):0]     b_level_o,
  output logic                       skew_err_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

  logic [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];

  logic [PtrW-1:0] a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic [PtrW-1:0] b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [LvlW-1:0] a_level_q, a_level_d, b_level_q, b_level_d;
  logic            skew_err_q, skew_err_d;

  logic push_a, push_b, pop;

  // Ready comes from level alone, so a full lane refuses a push even on a pop cycle.
  assign a_ready_o   = (a_level_q != Full);
  assign b_ready_o   = (b_level_q != Full);
  assign out_valid_o = (a_level_q != '0) && (b_level_q != '0);

  assign push_a = a_valid_i && a_ready_o;
  assign push_b = b_valid_i && b_ready_o;
  assign pop    = out_valid_o && out_ready_i;

  assign out_a_o    = out_valid_o ? a_mem[a_rptr_q] : '0;
  assign out_b_o    = out_valid_o ? b_mem[b_rptr_q] : '0;
  assign a_level_o  = a_level_q;
  assign b_level_o  = b_level_q;
  assign skew_err_o = skew_err_q;

  always_comb begin
    a_wptr_d   = a_wptr_q;
    a_rptr_d   = a_rptr_q;
    b_wptr_d   = b_wptr_q;
    b_rptr_d   = b_rptr_q;
    a_level_d  = a_level_q;
    b_level_d  = b_level_q;
    skew_err_d = skew_err_q;
    if (clear_i) begin
      a_wptr_d   = '0;
      a_rptr_d   = '0;
      b_wptr_d   = '0;
      b_rptr_d   = '0;
      a_level_d  = '0;
      b_level_d  = '0;
      skew_err_d = 1'b0;
    end else begin
      if (push_a) a_wptr_d = a_wptr_q + PtrW'(1);
      if (push_b) b_wptr_d = b_wptr_q + PtrW'(1);
      if (pop) begin
        a_rptr_d = a_rptr_q + PtrW'(1);
        b_rptr_d = b_rptr_q + PtrW'(1);
      end
      if (push_a && !pop)      a_level_d = a_level_q + LvlW'(1);
      else if (!push_a && pop) a_level_d = a_level_q - LvlW'(1);
      if (push_b && !pop)      b_level_d = b_level_q + LvlW'(1);
      else if (!push_b && pop) b_level_d = b_level_q - LvlW'(1);
      if (((a_level_q == Full) && (b_level_q == '0)) ||
          ((b_level_q == Full) && (a_level_q == '0))) begin
        skew_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_wptr_q   <= '0;
      a_rptr_q   <= '0;
      b_wptr_q   <= '0;
      b_rptr_q   <= '0;
      a_level_q  <= '0;
      b_level_q  <= '0;
      skew_err_q <= 1'b0;
    end else begin
      a_wptr_q   <= a_wptr_d;
      a_rptr_q   <= a_rptr_d;
      b_wptr_q   <= b_wptr_d;
      b_rptr_q   <= b_rptr_d;
      a_level_q  <= a_level_d;
      b_level_q  <= b_level_d;
      skew_err_q <= skew_err_d;
    end
  end

  // Storage is deliberately not reset; pointers and levels define what is valid.
  always_ff @(posedge CLK) begin
    if (push_a && !clear_i) a_mem[a_wptr_q] <= a_data_i;
    if (push_b && !clear_i) b_mem[b_wptr_q] <= b_data_i;
  end

endmodule

// File: tb/tb_fdtd_stream_align.sv
// Directed bench for fdtd_stream_align: a queue-based lane model checked every
// cycle, plus literal expectations for each scenario.
module tb_fdtd_stream_align;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          clear_i = 1'b0;
  logic          a_valid_i = 1'b0, b_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [DW-1:0] a_data_i = '0, b_data_i = '0;
  logic          a_ready_o, b_ready_o, out_valid_o, skew_err_o;
  logic [DW-1:0] out_a_o, out_b_o;
  logic [LW-1:0] a_level_o, b_level_o;

  int n_tests = 0;
  int n_fail  = 0;

  fdtd_stream_align #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .clear_i(clear_i),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_a_o(out_a_o), .out_b_o(out_b_o),
    .a_level_o(a_level_o), .b_level_o(b_level_o), .skew_err_o(skew_err_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each lane is a bounded queue; the pair is the two queue heads.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          m_skew = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qa.delete(); qb.delete(); m_skew = 1'b0;
    end else if (clear_i) begin
      qa.delete(); qb.delete(); m_skew = 1'b0;
    end else begin
      automatic bit do_pop = (qa.size() > 0) && (qb.size() > 0) && out_ready_i;
      automatic bit do_pa  = a_valid_i && (qa.size() < DEPTH);
      automatic bit do_pb  = b_valid_i && (qb.size() < DEPTH);
      if ((qa.size() == DEPTH && qb.size() == 0) || (qb.size() == DEPTH && qa.size() == 0))
        m_skew = 1'b1;
      if (do_pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (do_pa) qa.push_back(a_data_i);
      if (do_pb) qb.push_back(b_data_i);
    end
  end

  always @(negedge CLK) begin
    automatic bit v = (qa.size() > 0) && (qb.size() > 0);
    check("a_ready", a_ready_o, qa.size() != DEPTH);
    check("b_ready", b_ready_o, qb.size() != DEPTH);
    check("out_valid", out_valid_o, v);
    check("out_a", out_a_o, v ? qa[0] : '0);
    check("out_b", out_b_o, v ? qb[0] : '0);
    check("a_level", a_level_o, qa.size());
    check("b_level", b_level_o, qb.size());
    check("skew_err", skew_err_o, m_skew);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int npop, ia, ib, cyc;
    bool_blk: begin end
    #1;
    check("rst_a_ready", a_ready_o, 1);
    check("rst_b_ready", b_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_a", out_a_o, 0);
    check("rst_levels", {a_level_o, b_level_o}, 0);
    check("rst_skew", skew_err_o, 0);
    tick(2);
    RST_N = 1'b1;

    // Skewed single pair: A at edge 0, B at edge 3.
    a_valid_i = 1; a_data_i = 32'h11; tick();
    a_valid_i = 0; tick(2);
    check("t1_not_yet", out_valid_o, 0);
    b_valid_i = 1; b_data_i = 32'h22; tick();
    b_valid_i = 0;
    check("t1_valid", out_valid_o, 1);
    check("t1_a", out_a_o, 32'h11);
    check("t1_b", out_b_o, 32'h22);
    out_ready_i = 1; tick(); out_ready_i = 0;
    check("t1_drained", {a_level_o, b_level_o}, 0);

    // Streaming with no bubbles.
    a_valid_i = 1; b_valid_i = 1; out_ready_i = 1;
    for (int i = 0; i < 16; i++) begin
      a_data_i = 32'h100 + i; b_data_i = 32'h100 + i;
      tick();
      check("t2_pair_a", out_a_o, 32'h100 + i);
      check("t2_valid", out_valid_o, 1);
      check("t2_level_le1", (a_level_o <= 1) && (b_level_o <= 1), 1);
    end
    a_valid_i = 0; b_valid_i = 0; tick();
    check("t2_empty", out_valid_o, 0);
    out_ready_i = 0;

    // Skew fill on A, then B catches up.
    a_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      a_data_i = 32'hA0 + i; tick();
    end
    check("t3_a_full", a_ready_o, 0);
    check("t3_skew_lag", skew_err_o, 0);
    a_data_i = 32'hEE; tick();
    check("t3_skew_set", skew_err_o, 1);
    check("t3_5th_held", a_level_o, 4);
    a_valid_i = 0;
    b_valid_i = 1; out_ready_i = 1;
    b_data_i = 32'h1; tick();
    check("t3_first_a", out_a_o, 32'hA0);
    check("t3_first_b", out_b_o, 32'h1);
    for (int i = 2; i <= 4; i++) begin
      b_data_i = i; tick();
      check("t3_order", out_a_o, 32'hA0 + i - 1);
    end
    b_valid_i = 0; tick();
    check("t3_a_ready_back", a_ready_o, 1);
    check("t3_skew_sticky", skew_err_o, 1);
    out_ready_i = 0;

    // Backpressure holds the pair stable.
    clear_i = 1; tick(); clear_i = 0;
    check("t4_clr_skew", skew_err_o, 0);
    a_valid_i = 1; b_valid_i = 1;
    for (int i = 0; i < 2; i++) begin
      a_data_i = 32'h200 + i; b_data_i = 32'h300 + i; tick();
    end
    a_valid_i = 0; b_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stable", {out_valid_o, out_a_o, out_b_o}, {1'b1, 32'h200, 32'h300});
    end
    out_ready_i = 1; tick();
    check("t4_second", out_a_o, 32'h201);
    tick();
    check("t4_drained", out_valid_o, 0);
    out_ready_i = 0;

    // Wrap-around with toggling out_ready.
    npop = 0; ia = 0; ib = 0; cyc = 0;
    while ((ia < 10 || ib < 10 || out_valid_o) && cyc < 200) begin
      automatic bit acc_a, acc_b;
      a_valid_i = (ia < 10); a_data_i = 32'h400 + ia;
      b_valid_i = (ib < 10); b_data_i = 32'h500 + ib;
      out_ready_i = cyc[0];
      acc_a = a_valid_i && a_ready_o;
      acc_b = b_valid_i && b_ready_o;
      if (out_valid_o && out_ready_i) begin
        check("t5_pop_a", out_a_o, 32'h400 + npop);
        check("t5_pop_b", out_b_o, 32'h500 + npop);
        npop++;
      end
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
      cyc++;
    end
    a_valid_i = 0; b_valid_i = 0; out_ready_i = 0;
    check("t5_pop_count", npop, 10);
    check("t5_in_budget", cyc < 200, 1);

    // Clear beats a simultaneous push and pop.
    a_valid_i = 1; b_valid_i = 1; a_data_i = 32'h600; b_data_i = 32'h700; tick();
    b_valid_i = 0;
    a_data_i = 32'h601; tick();
    a_data_i = 32'h602; tick();
    check("t6_levels", {a_level_o, b_level_o}, {LW'(3), LW'(1)});
    clear_i = 1; a_data_i = 32'h6FF; out_ready_i = 1; tick();
    clear_i = 0; a_valid_i = 0; out_ready_i = 0;
    check("t6_cleared", {a_level_o, b_level_o, out_valid_o, skew_err_o}, 0);
    a_valid_i = 1; b_valid_i = 1; a_data_i = 32'h800; b_data_i = 32'h900; tick();
    a_valid_i = 0; b_valid_i = 0;
    check("t6_no_stale", out_a_o, 32'h800);
    check("t6_level_one", a_level_o, 1);

    // Asynchronous reset mid-operation.
    #2 RST_N = 0; #1;
    check("t7_async_rst", {out_valid_o, a_level_o, b_level_o, a_ready_o}, 1);
    tick(); RST_N = 1;
    a_valid_i = 1; b_valid_i = 1; a_data_i = 32'h55; b_data_i = 32'h66; tick();
    a_valid_i = 0; b_valid_i = 0;
    check("t7_after_rst", {out_a_o, out_b_o}, {32'h55, 32'h66});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
